// File: rtl/conv_row_sched.sv
// rtl/conv_row_sched.sv - raster writer into four rotating row banks and 3-row conv pass sequencer
// Optional stall counter is built only when CONV_SCHED_STATS_EN is defined.
module conv_row_sched #(
  parameter int BIT_DEPTH    = 8,
  parameter int IMAGE_WIDTH  = 28,
  parameter int IMAGE_HEIGHT = 28
) (
  input  logic                   clk,
  input  logic                   RESET,
  input  logic                   pix_valid,
  input  logic [BIT_DEPTH*3-1:0] pix_data,
  output logic                   pix_ready,
  output logic [3:0]             wr_en,
  output logic [4:0]             wr_addr,
  output logic [BIT_DEPTH*3-1:0] wr_data,
  output logic                   start_rd,
  input  logic                   fin_rd,
  output logic [1:0]             row_sel,
  output logic                   frame_done,
  output logic                   busy,
  output logic [15:0]            stall_cnt
);

  localparam int PW = BIT_DEPTH * 3;
  localparam int RW = $clog2(IMAGE_HEIGHT + 1);
  localparam logic [4:0]    COL_LAST  = 5'(IMAGE_WIDTH - 1);
  localparam logic [RW-1:0] ROW_COUNT = RW'(IMAGE_HEIGHT);
  localparam logic [RW-1:0] LAST_PASS = RW'(IMAGE_HEIGHT - 3);
  localparam logic [RW:0]   WINDOW    = (RW + 1)'(3);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_RUN, S_GAP, S_DRAIN} state_t;

  state_t        state_q, state_d;
  logic [4:0]    wr_col_q, wr_col_d;
  // rows_q counts completed rows and doubles as the index of the row being filled
  logic [RW-1:0] rows_q, rows_d;
  logic [RW-1:0] pass_q, pass_d;
  logic [2:0]    occ_q, occ_d;
  logic [3:0]    wr_en_q, wr_en_d;
  logic [4:0]    wr_addr_q, wr_addr_d;
  logic [PW-1:0] wr_data_q, wr_data_d;

  logic accept;
  logic row_done;
  logic retire;
  logic rows_avail;

  assign pix_ready  = !RESET && (occ_q < 3'd4) && (rows_q < ROW_COUNT);
  assign accept     = pix_valid && pix_ready;
  assign row_done   = accept && (wr_col_q == COL_LAST);
  assign retire     = (state_q == S_RUN) && fin_rd;
  assign rows_avail = ({1'b0, rows_q} >= ({1'b0, pass_q} + WINDOW));

  always_comb begin
    state_d   = state_q;
    wr_col_d  = wr_col_q;
    rows_d    = rows_q;
    pass_d    = pass_q;
    occ_d     = occ_q;
    wr_en_d   = 4'b0000;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    if (accept) begin
      wr_en_d   = 4'b0001 << rows_q[1:0];
      wr_addr_d = wr_col_q;
      wr_data_d = pix_data;
      if (row_done) begin
        wr_col_d = 5'd0;
        rows_d   = rows_q + RW'(1);
      end else begin
        wr_col_d = wr_col_q + 5'd1;
      end
    end

    // a row completing in the same cycle as a retire leaves occupancy unchanged
    case ({row_done, retire})
      2'b10:   occ_d = occ_q + 3'd1;
      2'b01:   occ_d = occ_q - 3'd1;
      default: occ_d = occ_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (rows_avail) state_d = S_RUN;
      end
      S_RUN: begin
        if (fin_rd) state_d = S_GAP;
      end
      S_GAP: begin
        if (pass_q == LAST_PASS) begin
          state_d = S_DRAIN;
        end else begin
          pass_d  = pass_q + RW'(1);
          state_d = S_WAIT;
        end
      end
      S_DRAIN: begin
        // the two rows left in the final window are dropped along with everything else
        state_d  = S_IDLE;
        wr_col_d = 5'd0;
        rows_d   = '0;
        pass_d   = '0;
        occ_d    = 3'd0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= S_IDLE;
      wr_col_q  <= 5'd0;
      rows_q    <= '0;
      pass_q    <= '0;
      occ_q     <= 3'd0;
      wr_en_q   <= 4'b0000;
      wr_addr_q <= 5'd0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_col_q  <= wr_col_d;
      rows_q    <= rows_d;
      pass_q    <= pass_d;
      occ_q     <= occ_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign start_rd   = (state_q == S_RUN);
  assign row_sel    = pass_q[1:0];
  assign frame_done = (state_q == S_DRAIN);
  assign busy       = (state_q == S_WAIT) || (state_q == S_RUN) || (state_q == S_GAP);

`ifdef CONV_SCHED_STATS_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (frame_done) begin
      stall_cnt_d = 16'd0;
    end else if (pix_valid && !pix_ready && busy && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      stall_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_conv_row_sched.sv
// tb/tb_conv_row_sched.sv - scoreboard bench for conv_row_sched with a frame-level reference model
module tb_conv_row_sched;

  localparam int BD = 8;
  localparam int W  = 28;
  localparam int H  = 28;
  localparam int PW = BD * 3;

  logic          clk = 1'b0;
  logic          RESET;
  logic          pix_valid;
  logic [PW-1:0] pix_data;
  logic          pix_ready;
  logic [3:0]    wr_en;
  logic [4:0]    wr_addr;
  logic [PW-1:0] wr_data;
  logic          start_rd;
  logic          fin_rd;
  logic [1:0]    row_sel;
  logic          frame_done;
  logic          busy;
  logic [15:0]   stall_cnt;

  always #5 clk = ~clk;

  conv_row_sched #(.BIT_DEPTH(BD), .IMAGE_WIDTH(W), .IMAGE_HEIGHT(H)) dut (
    .clk(clk), .RESET(RESET), .pix_valid(pix_valid), .pix_data(pix_data),
    .pix_ready(pix_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start_rd(start_rd), .fin_rd(fin_rd), .row_sel(row_sel), .frame_done(frame_done),
    .busy(busy), .stall_cnt(stall_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // stimulus controls
  bit drv_en      = 1'b0;
  int valid_pct   = 100;
  bit rand_fin    = 1'b0;
  int fin_fixed   = 40;
  bit spurious_en = 1'b0;

  initial begin
    pix_valid = 1'b0;
    pix_data  = '0;
    forever begin
      @(posedge clk);
      #1;
      if (drv_en) begin
        pix_valid = ($urandom_range(0, 99) < valid_pct);
        pix_data  = PW'($urandom);
      end else begin
        pix_valid = 1'b0;
      end
    end
  end

  // conv layer stand-in: answers each pass with fin_rd after a chosen delay
  int run_cnt   = 0;
  int cur_delay = 40;
  initial begin
    fin_rd = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      fin_rd = 1'b0;
      if (start_rd) begin
        if (run_cnt == 0) cur_delay = rand_fin ? int'($urandom_range(1, 60)) : fin_fixed;
        run_cnt++;
        if (run_cnt == cur_delay) fin_rd = 1'b1;
      end else begin
        run_cnt = 0;
        if (spurious_en && ($urandom_range(0, 15) == 0)) fin_rd = 1'b1;
      end
    end
  end

  // reference model state: pixels accepted and passes retired in the current frame
  typedef struct packed {
    logic [3:0]    en;
    logic [4:0]    addr;
    logic [PW-1:0] data;
  } wr_t;

  wr_t        wq[$];
  bit         mon_en           = 1'b0;
  int         cyc              = 0;
  int         acc_n            = 0;
  int         retired          = 0;
  int         last_fin_cyc     = -10;
  int         row2_cyc         = -1;
  int         rises_in_frame   = 0;
  int         last_frame_rises = 0;
  int         frames_done      = 0;
  int         exp_stall        = 0;
  bit         frame_active     = 1'b0;
  bit         prev_start       = 1'b0;
  bit         prev_retire      = 1'b0;
  logic [1:0] prev_row_sel     = 2'd0;

  function automatic logic [3:0] window_mask(input int k);
    logic [3:0] m;
    m = 4'b0000;
    for (int i = 0; i < 3; i++) m[(k + i) % 4] = 1'b1;
    return m;
  endfunction

  task automatic clear_model();
    acc_n          = 0;
    retired        = 0;
    last_fin_cyc   = -10;
    row2_cyc       = -1;
    rises_in_frame = 0;
    frame_active   = 1'b0;
    exp_stall      = 0;
  endtask

  task automatic monitor_step();
    int   rows;
    bit   m_ready, m_drain, m_busy, hs, ret;
    wr_t  got, w;
    cyc++;
    rows    = acc_n / W;
    m_ready = !RESET && ((rows - retired) < 4) && (rows < H);
    check("pix_ready", pix_ready, m_ready);

    got = {wr_en, wr_addr, wr_data};
    if (wq.size() > 0) begin
      w = wq.pop_front();
      check("write", got, w);
    end else begin
      check("wr_idle", wr_en, 4'b0000);
    end

    if (start_rd && (wr_en != 4'b0000))
      check("window_write", wr_en & window_mask(retired), 4'b0000);

    if (start_rd && !prev_start) begin
      check("row_sel", row_sel, retired % 4);
      check("rows_resident", rows >= retired + 3, 1);
      if (retired == 0 && row2_cyc >= 0) check("first_start_latency", cyc, row2_cyc + 2);
      rises_in_frame++;
    end else if (start_rd) begin
      check("row_sel_stable", row_sel, prev_row_sel);
    end

    if (prev_retire) check("gap_low", start_rd, 0);

    m_drain = frame_active && (retired == H - 2) && (cyc == last_fin_cyc + 2);
    m_busy  = frame_active && !m_drain;
    check("frame_done", frame_done, m_drain);
    check("busy", busy, m_busy);
`ifdef CONV_SCHED_STATS_EN
    check("stall_cnt", stall_cnt, exp_stall);
`else
    check("stall_cnt", stall_cnt, 0);
`endif

    hs           = m_ready && pix_valid;
    ret          = fin_rd && start_rd && !RESET;
    prev_start   = start_rd;
    prev_row_sel = row_sel;
    prev_retire  = ret;

    if (RESET) begin
      clear_model();
      wq.delete();
      prev_start  = 1'b0;
      prev_retire = 1'b0;
      return;
    end

    if (pix_valid && !m_ready && m_busy && exp_stall < 16'hFFFF) exp_stall++;
    if (hs) begin
      wq.push_back({4'b0001 << ((acc_n / W) % 4), 5'(acc_n % W), pix_data});
      if ((acc_n % W == W - 1) && (acc_n / W == 2)) row2_cyc = cyc;
      acc_n++;
      frame_active = 1'b1;
    end
    if (ret) begin
      retired++;
      last_fin_cyc = cyc;
    end
    if (m_drain) begin
      last_frame_rises = rises_in_frame;
      frames_done++;
      clear_model();
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) monitor_step();
  end

  task automatic wait_frame(input int limit);
    int  f0;
    bit  seen;
    f0   = frames_done;
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      #1;
      if (frames_done != f0) seen = 1'b1;
    end
    check("frame_complete", seen, 1);
  endtask

  initial begin
    bit hit;
    RESET = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_start_rd", start_rd, 0);
    check("rst_row_sel", row_sel, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_busy", busy, 0);
    check("rst_stall_cnt", stall_cnt, 0);

    @(posedge clk);
    #1;
    RESET  = 1'b0;
    mon_en = 1'b1;
    drv_en = 1'b1;

    // continuous input, 40-cycle passes
    wait_frame(20000);
    check("passes_frame1", last_frame_rises, H - 2);

    // slow conv layer forces the producer into occupancy stalls
    fin_fixed = 200;
    wait_frame(20000);
    check("passes_frame2", last_frame_rises, H - 2);

    // random traffic, spurious fin_rd, reset in the middle of pass 10
    valid_pct   = 75;
    rand_fin    = 1'b1;
    spurious_en = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20000 && !hit; i++) begin
      @(negedge clk);
      #1;
      if (retired == 10 && start_rd) hit = 1'b1;
    end
    check("reach_pass10", hit, 1);
    @(posedge clk);
    #1;
    RESET = 1'b1;
    @(posedge clk);
    #1;
    RESET = 1'b0;
    @(negedge clk);
    check("rst_mid_start_rd", start_rd, 0);
    check("rst_mid_wr_en", wr_en, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_row_sel", row_sel, 0);

    wait_frame(20000);
    check("passes_after_reset", last_frame_rises, H - 2);

    drv_en = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("idle_busy", busy, 0);
    check("idle_start_rd", start_rd, 0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_row_sched.md
# conv_row_sched

Row scheduler for the 3x3 convolution datapath. It writes an incoming raster pixel stream, row by row, into four rotating row-buffer banks. It decides when enough rows are resident to launch a convolution pass, and sequences `start_rd`/`fin_rd` with the conv layer once per output row. It supplies the bank-rotation index for each pass and throttles the producer so that no bank in the active 3-row read window is overwritten.

## Interface
Parameters:
- `BIT_DEPTH`, 8, bits per colour channel; a pixel word is `BIT_DEPTH*3` bits.
- `IMAGE_WIDTH`, 28, pixels per row (≤ 32, since `wr_addr` is 5 bits).
- `IMAGE_HEIGHT`, 28, rows per frame (≥ 3).

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `RESET`  in  1  reset, synchronous, active-high.
- `pix_valid`  in  1  producer pixel valid.
- `pix_data`  in  `BIT_DEPTH*3`  pixel, channels {a,b,c} MSB to LSB.
- `pix_ready`  out  1  scheduler accepts pixel; transfer when `pix_valid && pix_ready`.
- `wr_en`  out  4  one-hot bank write enable (bit n → bank n).
- `wr_addr`  out  5  column write address.
- `wr_data`  out  `BIT_DEPTH*3`  registered copy of the accepted pixel.
- `start_rd`  out  1  level; held high for one conv pass.
- `fin_rd`  in  1  one-cycle pulse from the conv layer marking end of pass.
- `row_sel`  out  2  bank rotation index for the current pass (`pass_idx mod 4`).
- `frame_done`  out  1  one-cycle pulse after the last pass of a frame.
- `busy`  out  1  high from the first accepted pixel until `frame_done`.
- `stall_cnt`  out  16  producer stall counter (see Configuration).

## Operation
- Counters:
  - `wr_col` 0..`IMAGE_WIDTH`-1 and `wr_row` 0..`IMAGE_HEIGHT`-1 for the write side.
  - `pass_idx` 0..`IMAGE_HEIGHT`-3.
  - `occ` 0..4, rows written but not retired.
- Write side:
  - An accepted pixel goes to bank `wr_row mod 4` at address `wr_col`.
  - `wr_col` wraps to 0 after `IMAGE_WIDTH`-1; at that wrap the row completes, `wr_row` increments and `occ` increments.
- `pix_ready` = !RESET && `occ` < 4 && `rows_written` < `IMAGE_HEIGHT`. It is combinational from registered state.
  - A row in progress counts toward `occ` only once it completes, so bank `(pass_idx+3) mod 4` may be filled while pass `pass_idx` is running.
- Pass window: pass k reads banks k, k+1, k+2 (mod 4) and `row_sel` = k mod 4. Pass k needs `rows_written` ≥ k+3.
- FSM states:
  - `IDLE`: everything at 0. Goes to `WAIT` on the first accepted pixel, and `busy` rises.
  - `WAIT`: waits for `rows_written` ≥ `pass_idx`+3, then goes to `RUN`.
  - `RUN`: `start_rd` = 1 and `row_sel` is stable. On `fin_rd`, row `pass_idx` retires (`occ` −1) and the FSM goes to `GAP`.
  - `GAP`: `start_rd` = 0 for exactly one cycle. If `pass_idx` = `IMAGE_HEIGHT`-3, go to `DRAIN`. Otherwise `pass_idx`+1 and go to `WAIT`.
  - `DRAIN`: retires the remaining 2 rows (`occ` → 0), pulses `frame_done` for 1 cycle, clears all counters, `busy` = 0, then goes to `IDLE`.
- Boundary rules:
  - Row completion and `fin_rd` retire in the same cycle leave `occ` unchanged.
  - `fin_rd` outside `RUN` is ignored.
  - A pixel offered during `DRAIN` is not accepted, because `rows_written` = `IMAGE_HEIGHT` keeps `pix_ready` low.
- `RESET` mid-frame drops `start_rd`, `wr_en` and `busy` on the next edge and discards all stored rows. A pixel presented in the reset cycle is not accepted.

## Timing
- Reset values: `pix_ready` 0, `wr_en` 0, `wr_addr` 0, `wr_data` 0, `start_rd` 0, `row_sel` 0, `frame_done` 0, `busy` 0, `stall_cnt` 0.
- Write latency: a pixel accepted at edge t appears on `wr_en`/`wr_addr`/`wr_data` for the single cycle after edge t, i.e. 1 cycle.
- Row completion becomes visible to `occ` and to the `WAIT` condition at that same edge t. `start_rd` then rises at edge t+1, the earliest point.
- `start_rd` falls at the edge sampling `fin_rd`. The minimum low time between passes is 1 cycle (`GAP`), or longer if rows are not yet resident.
- `row_sel` changes only in `GAP`, never while `start_rd` = 1.
- `frame_done` comes 2 cycles after the `fin_rd` of the last pass (`GAP`, then `DRAIN`).
- With continuous input, the producer stalls only once 4 unretired rows are present.

## Configuration
- `CONV_SCHED_STATS_EN` defined:
  - `stall_cnt` increments every cycle with `pix_valid` && !`pix_ready` && `busy`.
  - It saturates at 16'hFFFF and clears on `RESET` or on `frame_done`.
- Not defined: `stall_cnt` is tied to 0 and no counter logic is built.

## Test plan
- Reset, then a 28x28 frame with `pix_valid` held 1 and a conv model returning `fin_rd` 40 cycles after `start_rd` → 26 `start_rd` pulses with `row_sel` sequence 0,1,2,3,0…; `frame_done` once, 2 cycles after the 26th `fin_rd`; `busy` low afterwards.
- Same frame with `fin_rd` delayed 200 cycles → `pix_ready` drops with `occ` = 4, never while `occ` < 4. Bank `row_sel` through `row_sel`+2 (mod 4) never sees `wr_en` during `RUN`. With the macro on, `stall_cnt` equals the bench's stall count.
- Last pixel of row 2 accepted at edge t → `wr_en` = 4'b0100 with `wr_addr` = 27 after edge t; `start_rd` = 1 after edge t+1 with `row_sel` = 0.
- Row completion and `fin_rd` in the same cycle → `occ` unchanged. A spurious `fin_rd` during `WAIT` → no state change, no retire.
- `RESET` asserted during pass 10 → the next cycle has `start_rd` = 0, `wr_en` = 0, `busy` = 0. A fresh frame afterwards completes normally, starting with `row_sel` = 0.
